// File: rtl/prog_fault_mem_pkg.sv
// Shared fault-type encoding and per-slot configuration record for prog_fault_mem.
package prog_fault_mem_pkg;

    localparam int unsigned FT_W       = 3;
    localparam int unsigned CFG_ADDR_W = 16;
    localparam int unsigned CFG_BIT_W  = 8;

    typedef enum logic [FT_W-1:0] {
        FT_NONE    = 3'd0,
        FT_SAF0    = 3'd1,
        FT_SAF1    = 3'd2,
        FT_TF_UP   = 3'd3,
        FT_TF_DOWN = 3'd4,
        FT_CFIN    = 3'd5,
        FT_RDF     = 3'd6,
        FT_RSVD    = 3'd7
    } fault_type_e;

    // Field widths are upper bounds so the record is independent of the memory parameters.
    typedef struct packed {
        fault_type_e           ftype;
        logic [CFG_ADDR_W-1:0] vaddr;
        logic [CFG_BIT_W-1:0]  vbit;
        logic [CFG_ADDR_W-1:0] agg_addr;
        logic [CFG_BIT_W-1:0]  agg_bit;
    } slot_cfg_t;

    function automatic fault_type_e eff_type(input slot_cfg_t c);
        if (c.ftype == FT_RSVD) return FT_NONE;
        if (c.ftype == FT_CFIN && c.agg_addr == c.vaddr) return FT_NONE;
        return c.ftype;
    endfunction

endpackage

// File: rtl/prog_fault_mem_fault_slot_eval.sv
// One fault slot: applies its configured fault to the in-flight word of the current command.
module fault_slot_eval
    import prog_fault_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned CAPACITY   = 16
) (
    input  logic                  cmd_vld_i,
    input  logic                  is_write_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  slot_cfg_t             cfg_i,
    input  logic [DATA_WIDTH-1:0] store_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] store_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  flip_o,
    output logic                  act_o
);
    logic [DATA_WIDTH-1:0] vmask;
    logic [DATA_WIDTH-1:0] amask;
    logic                  hit_v;
    logic                  hit_a;

    // On writes data_i is the word to be stored; on reads it is the word being returned.
    always_comb begin
        vmask   = DATA_WIDTH'(1) << cfg_i.vbit;
        amask   = DATA_WIDTH'(1) << cfg_i.agg_bit;
        hit_v   = cmd_vld_i && (CFG_ADDR_W'(addr_i) == cfg_i.vaddr) && (vmask != '0);
        hit_a   = cmd_vld_i && (CFG_ADDR_W'(addr_i) == cfg_i.agg_addr) && (amask != '0);
        store_o = store_i;
        data_o  = data_i;
        flip_o  = 1'b0;
        act_o   = 1'b0;
        case (eff_type(cfg_i))
            FT_SAF0: if (hit_v && (data_i & vmask) != '0) begin
                data_o = data_i & ~vmask;
                act_o  = 1'b1;
            end
            FT_SAF1: if (hit_v && (data_i & vmask) == '0) begin
                data_o = data_i | vmask;
                act_o  = 1'b1;
            end
            FT_TF_UP: if (hit_v && is_write_i && (data_i & vmask) != '0 && (store_i & vmask) == '0) begin
                data_o = data_i & ~vmask;
                act_o  = 1'b1;
            end
            FT_TF_DOWN: if (hit_v && is_write_i && (data_i & vmask) == '0 && (store_i & vmask) != '0) begin
                data_o = data_i | vmask;
                act_o  = 1'b1;
            end
            FT_CFIN: if (hit_a && is_write_i && (store_i & amask) == '0 && (data_i & amask) != '0
                         && vmask != '0 && cfg_i.vaddr < CFG_ADDR_W'(CAPACITY)) begin
                flip_o = 1'b1;
                act_o  = 1'b1;
            end
            FT_RDF: if (hit_v && !is_write_i) begin
                data_o  = data_i ^ vmask;
                store_o = store_i ^ vmask;
                act_o   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/prog_fault_mem.sv
// Programmable faulty memory: registered write data, two-stage read, NUM_FAULTS chained fault slots.
module prog_fault_mem
    import prog_fault_mem_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned ADDR_WIDTH = 4,
    parameter  int unsigned CAPACITY   = 16,
    parameter  int unsigned NUM_FAULTS = 2,
    localparam int unsigned BIT_W      = $clog2(DATA_WIDTH),
    localparam int unsigned SLOT_W     = (NUM_FAULTS > 1) ? $clog2(NUM_FAULTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_read,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    input  logic                  cfg_we,
    input  logic [SLOT_W-1:0]     cfg_slot,
    input  logic [2:0]            cfg_type,
    input  logic [ADDR_WIDTH-1:0] cfg_addr,
    input  logic [BIT_W-1:0]      cfg_bit,
    input  logic [ADDR_WIDTH-1:0] cfg_agg_addr,
    input  logic [BIT_W-1:0]      cfg_agg_bit,
    output logic [7:0]            fault_cnt
);
    slot_cfg_t             slot_q [NUM_FAULTS];
    slot_cfg_t             slot_d [NUM_FAULTS];
    logic [DATA_WIDTH-1:0] mem_q  [CAPACITY];
    logic [DATA_WIDTH-1:0] mem_d  [CAPACITY];
    logic [DATA_WIDTH-1:0] st_o   [NUM_FAULTS];
    logic [DATA_WIDTH-1:0] dt_o   [NUM_FAULTS];
    logic [NUM_FAULTS-1:0] flip;
    logic [NUM_FAULTS-1:0] act;
    logic [DATA_WIDTH-1:0] wdata_q, stage1_q, stage1_d, rdata_q, rdata_d, cur_word, dt0;
    logic                  s1_vld_q, s1_vld_d, rvalid_q, rvalid_d, cmd_vld;
    logic [7:0]            cnt_q, cnt_d;
    int unsigned           n_act;

    always_comb begin
        cmd_vld  = !rst && (32'(address) < CAPACITY);
        cur_word = '0;
        for (int unsigned w = 0; w < CAPACITY; w++)
            if (ADDR_WIDTH'(w) == address) cur_word = mem_q[w];
        dt0 = write_read ? wdata_q : cur_word;
    end

    for (genvar g = 0; g < NUM_FAULTS; g++) begin : g_slot
        logic [DATA_WIDTH-1:0] st_in;
        logic [DATA_WIDTH-1:0] dt_in;
        if (g == 0) begin : g_first
            assign st_in = cur_word;
            assign dt_in = dt0;
        end else begin : g_next
            assign st_in = st_o[g-1];
            assign dt_in = dt_o[g-1];
        end
        fault_slot_eval #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .CAPACITY   (CAPACITY)
        ) u_eval (
            .cmd_vld_i  (cmd_vld),
            .is_write_i (write_read),
            .addr_i     (address),
            .cfg_i      (slot_q[g]),
            .store_i    (st_in),
            .data_i     (dt_in),
            .store_o    (st_o[g]),
            .data_o     (dt_o[g]),
            .flip_o     (flip[g]),
            .act_o      (act[g])
        );
    end

    // CFIN victims never share an address with the written aggressor, so flips and the write commute.
    always_comb begin
        for (int unsigned w = 0; w < CAPACITY; w++) mem_d[w] = mem_q[w];
        if (cmd_vld)
            for (int unsigned w = 0; w < CAPACITY; w++)
                if (ADDR_WIDTH'(w) == address)
                    mem_d[w] = write_read ? dt_o[NUM_FAULTS-1] : st_o[NUM_FAULTS-1];
        for (int unsigned s = 0; s < NUM_FAULTS; s++)
            if (flip[s])
                for (int unsigned w = 0; w < CAPACITY; w++)
                    if (CFG_ADDR_W'(w) == slot_q[s].vaddr)
                        mem_d[w] = mem_d[w] ^ (DATA_WIDTH'(1) << slot_q[s].vbit);
    end

    always_comb begin
        n_act = 0;
        for (int unsigned s = 0; s < NUM_FAULTS; s++) n_act = n_act + 32'(act[s]);
        cnt_d = (32'(cnt_q) + n_act > 32'd255) ? 8'hFF : 8'(32'(cnt_q) + n_act);

        for (int unsigned s = 0; s < NUM_FAULTS; s++) slot_d[s] = slot_q[s];
        if (cfg_we && 32'(cfg_slot) < NUM_FAULTS)
            for (int unsigned s = 0; s < NUM_FAULTS; s++)
                if (SLOT_W'(s) == cfg_slot) begin
                    slot_d[s].ftype    = fault_type_e'(cfg_type);
                    slot_d[s].vaddr    = CFG_ADDR_W'(cfg_addr);
                    slot_d[s].vbit     = CFG_BIT_W'(cfg_bit);
                    slot_d[s].agg_addr = CFG_ADDR_W'(cfg_agg_addr);
                    slot_d[s].agg_bit  = CFG_BIT_W'(cfg_agg_bit);
                end

        stage1_d = stage1_q;
        s1_vld_d = 1'b0;
        if (!write_read) begin
            stage1_d = cmd_vld ? dt_o[NUM_FAULTS-1] : '0;
            s1_vld_d = 1'b1;
        end
        rdata_d  = s1_vld_q ? stage1_q : rdata_q;
        rvalid_d = s1_vld_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdata_q  <= '0;
            stage1_q <= '0;
            s1_vld_q <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            cnt_q    <= '0;
            for (int unsigned s = 0; s < NUM_FAULTS; s++) slot_q[s] <= '0;
        end else begin
            wdata_q  <= wdata;
            stage1_q <= stage1_d;
            s1_vld_q <= s1_vld_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            cnt_q    <= cnt_d;
            for (int unsigned s = 0; s < NUM_FAULTS; s++) slot_q[s] <= slot_d[s];
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned w = 0; w < CAPACITY; w++) mem_q[w] <= mem_d[w];
    end

    assign rdata     = rdata_q;
    assign rvalid    = rvalid_q;
    assign fault_cnt = cnt_q;

endmodule

// File: tb/tb_prog_fault_mem.sv
// Randomised and directed bench for prog_fault_mem against a behavioural memory/fault model.
module tb_prog_fault_mem;

    localparam int CAP = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       write_read = 1'b0;
    logic [3:0] address = '0;
    logic [7:0] wdata = '0;
    logic       cfg_we = 1'b0;
    logic [0:0] cfg_slot = '0;
    logic [2:0] cfg_type = '0;
    logic [3:0] cfg_addr = '0;
    logic [2:0] cfg_bit = '0;
    logic [3:0] cfg_agg_addr = '0;
    logic [2:0] cfg_agg_bit = '0;
    logic [7:0] rdata;
    logic       rvalid;
    logic [7:0] fault_cnt;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model state
    logic [7:0] m_mem [16];
    int         m_type [2];
    int         m_va [2], m_vb [2], m_aa [2], m_ab [2];
    logic [7:0] m_wdq, m_s1, m_rdata;
    logic       m_s1v, m_rvalid;
    int         m_cnt;

    prog_fault_mem #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4),
        .CAPACITY   (CAP),
        .NUM_FAULTS (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .write_read   (write_read),
        .address      (address),
        .wdata        (wdata),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .cfg_we       (cfg_we),
        .cfg_slot     (cfg_slot),
        .cfg_type     (cfg_type),
        .cfg_addr     (cfg_addr),
        .cfg_bit      (cfg_bit),
        .cfg_agg_addr (cfg_agg_addr),
        .cfg_agg_bit  (cfg_agg_bit),
        .fault_cnt    (fault_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int eff(input int s);
        if (m_type[s] == 7) return 0;
        if (m_type[s] == 5 && m_va[s] == m_aa[s]) return 0;
        return m_type[s];
    endfunction

    task automatic model_edge();
        int         a, act, vb, ab;
        int         flp [2];
        logic [7:0] w, old, r, st;
        if (rst) begin
            m_rdata = '0; m_rvalid = 1'b0; m_cnt = 0; m_wdq = '0; m_s1 = '0; m_s1v = 1'b0;
            m_type[0] = 0; m_type[1] = 0;
        end else begin
            act = 0;
            a = int'(address);
            m_rvalid = m_s1v;
            if (m_s1v) m_rdata = m_s1;
            if (a < CAP) begin
                old = m_mem[a];
                if (write_read) begin
                    w = m_wdq;
                    for (int s = 0; s < 2; s++) begin
                        flp[s] = 0;
                        vb = m_vb[s];
                        ab = m_ab[s];
                        case (eff(s))
                            1: if (a == m_va[s] && w[vb]) begin w[vb] = 1'b0; act++; end
                            2: if (a == m_va[s] && !w[vb]) begin w[vb] = 1'b1; act++; end
                            3: if (a == m_va[s] && w[vb] && !old[vb]) begin w[vb] = 1'b0; act++; end
                            4: if (a == m_va[s] && !w[vb] && old[vb]) begin w[vb] = 1'b1; act++; end
                            5: if (a == m_aa[s] && !old[ab] && w[ab] && m_va[s] < CAP) begin flp[s] = 1; act++; end
                            default: ;
                        endcase
                    end
                    m_mem[a] = w;
                    for (int s = 0; s < 2; s++)
                        if (flp[s] != 0) m_mem[m_va[s]][m_vb[s]] = ~m_mem[m_va[s]][m_vb[s]];
                end else begin
                    r = old;
                    st = old;
                    for (int s = 0; s < 2; s++) begin
                        vb = m_vb[s];
                        if (a == m_va[s]) begin
                            case (eff(s))
                                1: if (r[vb]) begin r[vb] = 1'b0; act++; end
                                2: if (!r[vb]) begin r[vb] = 1'b1; act++; end
                                6: begin r[vb] = ~r[vb]; st[vb] = ~st[vb]; act++; end
                                default: ;
                            endcase
                        end
                    end
                    m_mem[a] = st;
                    m_s1 = r;
                end
            end else if (!write_read) begin
                m_s1 = '0;
            end
            m_s1v = !write_read;
            m_cnt = (m_cnt + act > 255) ? 255 : m_cnt + act;
            m_wdq = wdata;
            if (cfg_we) begin
                m_type[cfg_slot] = int'(cfg_type);
                m_va[cfg_slot]   = int'(cfg_addr);
                m_vb[cfg_slot]   = int'(cfg_bit);
                m_aa[cfg_slot]   = int'(cfg_agg_addr);
                m_ab[cfg_slot]   = int'(cfg_agg_bit);
            end
        end
    endtask

    task automatic cycle(input logic r, input logic we, input int a, input logic [7:0] wd,
                         input logic cw, input int slot, input int ty, input int va,
                         input int vb, input int aa, input int ab);
        rst = r; write_read = we; address = 4'(a); wdata = wd;
        cfg_we = cw; cfg_slot = 1'(slot); cfg_type = 3'(ty);
        cfg_addr = 4'(va); cfg_bit = 3'(vb); cfg_agg_addr = 4'(aa); cfg_agg_bit = 3'(ab);
        @(posedge clk);
        model_edge();
        #1;
        chk("rvalid", 32'(rvalid), 32'(m_rvalid));
        chk("rdata", 32'(rdata), 32'(m_rdata));
        chk("fault_cnt", 32'(fault_cnt), 32'(m_cnt));
    endtask

    task automatic cmd(input logic we, input int a, input logic [7:0] wd);
        cycle(1'b0, we, a, wd, 1'b0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cfg(input int slot, input int ty, input int va, input int vb, input int aa, input int ab);
        cycle(1'b0, 1'b1, 15, 8'h00, 1'b1, slot, ty, va, vb, aa, ab);
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        cmd(1'b1, 15, d);
        cmd(1'b1, a, d);
    endtask

    task automatic rd(input int a);
        cmd(1'b0, a, 8'h00);
        cmd(1'b1, 15, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        for (int s = 0; s < 2; s++) begin
            m_type[s] = 0; m_va[s] = 0; m_vb[s] = 0; m_aa[s] = 0; m_ab[s] = 0;
        end
        m_wdq = '0; m_s1 = '0; m_rdata = '0; m_s1v = 1'b0; m_rvalid = 1'b0; m_cnt = 0;

        cycle(1'b1, 1'b0, 0, 8'h00, 1'b0, 0, 0, 0, 0, 0, 0);
        cycle(1'b1, 1'b0, 0, 8'h00, 1'b0, 0, 0, 0, 0, 0, 0);
        chk("reset_rvalid", 32'(rvalid), 32'd0);
        chk("reset_cnt", 32'(fault_cnt), 32'd0);
        for (int a = 0; a < CAP; a++) cmd(1'b1, a, 8'h00);

        wr(3, 8'hA5); rd(3);
        chk("nofault_rdata", 32'(rdata), 32'hA5);
        chk("nofault_rvalid", 32'(rvalid), 32'd1);
        chk("nofault_cnt", 32'(fault_cnt), 32'd0);

        cfg(0, 3, 5, 0, 0, 0);
        wr(5, 8'h00); wr(5, 8'hFF); rd(5);
        chk("tfup_rdata", 32'(rdata), 32'hFE);
        chk("tfup_cnt", 32'(fault_cnt), 32'd1);
        cfg(0, 0, 0, 0, 0, 0);
        wr(5, 8'hFF); rd(5);
        chk("tfup_off_rdata", 32'(rdata), 32'hFF);

        cfg(1, 2, 2, 7, 0, 0);
        wr(2, 8'h00); rd(2);
        chk("saf1_rdata", 32'(rdata), 32'h80);
        chk("saf1_cnt", 32'(fault_cnt), 32'd2);
        wr(2, 8'h80); rd(2);
        chk("saf1_same_rdata", 32'(rdata), 32'h80);
        chk("saf1_same_cnt", 32'(fault_cnt), 32'd2);
        cfg(1, 0, 0, 0, 0, 0);

        cfg(0, 5, 9, 3, 1, 0);
        wr(1, 8'h00); wr(9, 8'h00); wr(1, 8'h01); rd(9);
        chk("cfin_rdata", 32'(rdata), 32'h08);
        wr(1, 8'h01); rd(9);
        chk("cfin_hold_rdata", 32'(rdata), 32'h08);
        chk("cfin_cnt", 32'(fault_cnt), 32'd3);
        cfg(0, 0, 0, 0, 0, 0);

        cfg(1, 6, 4, 2, 0, 0);
        wr(4, 8'h00); rd(4);
        chk("rdf_first", 32'(rdata), 32'h04);
        rd(4);
        chk("rdf_second", 32'(rdata), 32'h00);
        chk("rdf_cnt", 32'(fault_cnt), 32'd5);
        cfg(1, 0, 0, 0, 0, 0);

        // Config and command in the same edge: the write sees the old (empty) config.
        cmd(1'b1, 15, 8'hFF);
        cycle(1'b0, 1'b1, 6, 8'hFF, 1'b1, 0, 1, 6, 1, 0, 0);
        cfg(0, 0, 0, 0, 0, 0);
        rd(6);
        chk("cfg_timing_rdata", 32'(rdata), 32'hFF);

        wr(13, 8'h3C); rd(13);
        chk("oor_rdata", 32'(rdata), 32'h00);
        chk("oor_rvalid", 32'(rvalid), 32'd1);

        cfg(0, 3, 5, 0, 0, 0);
        cmd(1'b0, 5, 8'h00);
        cycle(1'b1, 1'b1, 15, 8'h00, 1'b0, 0, 0, 0, 0, 0, 0);
        chk("midrst_rdata", 32'(rdata), 32'h00);
        chk("midrst_rvalid", 32'(rvalid), 32'd0);
        chk("midrst_cnt", 32'(fault_cnt), 32'd0);
        cmd(1'b1, 15, 8'h00);
        rd(5);
        chk("midrst_retained", 32'(rdata), 32'hFF);
        wr(5, 8'h00); wr(5, 8'hFF); rd(5);
        chk("midrst_slots_none", 32'(rdata), 32'hFF);
        chk("midrst_cnt_after", 32'(fault_cnt), 32'd0);

        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 299) == 0),
                  1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 15)),
                  8'($urandom),
                  ($urandom_range(0, 7) == 0),
                  int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 7)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
